exe_muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer sitting beside the EXE-stage ALU. When the decoded instruction in ID/EXE is a MUL/MULHU/DIVU/REMU op, it captures the post-forwarding operands, runs a 1-bit-per-cycle shift-add or restoring-divide loop, and holds the pipeline stalled until the result is ready. The result then feeds the ALU-result mux into EX/MEM in the release cycle.

---
 rtl/exe_pkg.sv | 20 ++
 rtl/muldiv_datapath.sv | 69 ++++++
 rtl/exe_muldiv_ctrl.sv | 105 ++++++++++
 tb/tb_exe_muldiv_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared encodings for the EXE-stage iterative multiply/divide unit.
package exe_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath, one bit per step.
// r_acc holds the product high half or the remainder; r_mq holds the multiplier or quotient.
module muldiv_datapath
  import exe_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div_zero,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result_c
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_fit;
  logic             w_is_div;

  assign w_is_div  = r_op[1];
  assign w_mul_sum = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : (WIDTH+1)'(0));

  // Partial remainder shifted left with the next dividend bit; difference fits in WIDTH bits when taken.
  assign w_shift   = {r_acc, r_mq[WIDTH-1]};
  assign w_fit     = (w_shift >= {1'b0, r_b});
  assign w_diff    = w_shift[WIDTH-1:0] - r_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
      r_mq  <= '0;
      r_b   <= '0;
      r_op  <= '0;
    end else if (i_load) begin
      r_op <= i_op;
      r_b  <= i_b;
      // Divide-by-zero preloads the architected answer: quotient all ones, remainder = A.
      if (i_div_zero) begin
        r_acc <= i_a;
        r_mq  <= '1;
      end else begin
        r_acc <= '0;
        r_mq  <= i_a;
      end
    end else if (i_step) begin
      if (w_is_div) begin
        r_acc <= w_fit ? w_diff : w_shift[WIDTH-1:0];
        r_mq  <= {r_mq[WIDTH-2:0], w_fit};
      end else begin
        r_acc <= w_mul_sum[WIDTH:1];
        r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
      end
    end
  end

  // MUL/DIVU read r_mq, MULHU/REMU read r_acc.
  assign o_result_c = r_op[0] ? r_acc : r_mq;

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// EXE-stage mul/div sequencer: FSM and iteration counter; stalls the pipe until the result is ready.
module exe_muldiv_ctrl
  import exe_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_ID_EXE,
  input  logic [1:0]       op_ID_EXE,
  input  logic [WIDTH-1:0] A_FRWD,
  input  logic [WIDTH-1:0] B_FRWD,
  input  logic             flush,
  output logic             stall_EXE,
  output logic             done_EXE,
  output logic [WIDTH-1:0] result_EXE
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_stall;
  logic             w_done;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_dp_result;

  assign w_div_zero = ((op_ID_EXE == OP_DIVU) || (op_ID_EXE == OP_REMU)) && (B_FRWD == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_stall     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_ID_EXE && !flush) begin
          w_stall     = 1'b1;
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = w_div_zero ? DONE : RUN;
        end
      end
      RUN: begin
        w_stall   = 1'b1;
        w_step    = 1'b1;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // start_ID_EXE is still the same instruction here; it advances on this edge.
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_stall     = 1'b0;
      w_done      = 1'b0;
    end
  end

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_div_zero (w_div_zero),
    .i_op       (op_ID_EXE),
    .i_a        (A_FRWD),
    .i_b        (B_FRWD),
    .o_result_c (w_dp_result)
  );

  // Reset gates the combinational outputs too, so an asserted start cannot stall during reset.
  assign stall_EXE  = reset_n & w_stall;
  assign done_EXE   = reset_n & w_done;
  assign result_EXE = done_EXE ? w_dp_result : '0;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Scoreboard bench for exe_muldiv_ctrl: cycle-exact stall/done timing and result values.
module tb_exe_muldiv_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int LAT_FULL = 33;

  logic             clk;
  logic             reset_n;
  logic             start_ID_EXE;
  logic [1:0]       op_ID_EXE;
  logic [WIDTH-1:0] A_FRWD;
  logic [WIDTH-1:0] B_FRWD;
  logic             flush;
  logic             stall_EXE;
  logic             done_EXE;
  logic [WIDTH-1:0] result_EXE;

  int errors;
  int checks;
  logic [WIDTH-1:0] exp_q[$];

  exe_muldiv_ctrl #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_ID_EXE (start_ID_EXE),
    .op_ID_EXE    (op_ID_EXE),
    .A_FRWD       (A_FRWD),
    .B_FRWD       (B_FRWD),
    .flush        (flush),
    .stall_EXE    (stall_EXE),
    .done_EXE     (done_EXE),
    .result_EXE   (result_EXE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   return p[WIDTH-1:0];
      2'b01:   return p[2*WIDTH-1:WIDTH];
      2'b10:   return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts one op at the current cycle and checks every cycle through the IDLE cycle after DONE.
  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input string name);
    int lat;
    logic [WIDTH-1:0] got;
    lat = (op[1] && b == 0) ? 1 : LAT_FULL;
    exp_q.push_back(model(op, a, b));
    start_ID_EXE = 1'b1;
    op_ID_EXE    = op;
    A_FRWD       = a;
    B_FRWD       = b;
    for (int c = 0; c <= lat + 1; c++) begin
      @(negedge clk);
      checks++;
      if ({stall_EXE, done_EXE} !== {1'(c < lat), 1'(c == lat)}) begin
        errors++;
        $display("FAIL %s cycle %0d stall/done: got %b%b expected %b%b", name, c, stall_EXE, done_EXE,
                 1'(c < lat), 1'(c == lat));
      end
      if (done_EXE === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected done: result %h", name, result_EXE);
        end else begin
          got = exp_q.pop_front();
          if (result_EXE !== got) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, result_EXE, got);
          end
        end
      end else begin
        checks++;
        if (result_EXE !== '0) begin
          errors++;
          $display("FAIL %s cycle %0d result leak: got %h expected 0", name, c, result_EXE);
        end
      end
      next_cycle();
      if (c == lat) start_ID_EXE = 1'b0;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s no done: %0d results pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({stall_EXE, done_EXE, result_EXE} !== {2'b00, 32'd0}) begin
      errors++;
      $display("FAIL %s: stall=%b done=%b result=%h expected 0/0/0", name, stall_EXE, done_EXE, result_EXE);
    end
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    start_ID_EXE = 1'b1;
    op_ID_EXE    = 2'b00;
    A_FRWD       = 32'd5;
    B_FRWD       = 32'd5;
    flush        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset_outputs");
    start_ID_EXE = 1'b0;
    reset_n      = 1'b1;
    next_cycle();
    @(negedge clk);
    check_idle("after_reset_idle");
    next_cycle();
  endtask

  task automatic test_mul();
    run_op(2'b00, 32'd7, 32'd6, "mul_7x6");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
  endtask

  task automatic test_div();
    run_op(2'b10, 32'd100, 32'd7, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, "remu_100_7");
    run_op(2'b10, 32'd5, 32'd9, "divu_small");
  endtask

  task automatic test_div_zero();
    run_op(2'b10, 32'h1234, 32'd0, "divu_by_zero");
    run_op(2'b11, 32'h1234, 32'd0, "remu_by_zero");
  endtask

  task automatic test_flush();
    start_ID_EXE = 1'b1;
    op_ID_EXE    = 2'b10;
    A_FRWD       = 32'd1000;
    B_FRWD       = 32'd3;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) flush = 1'b1;
      @(negedge clk);
      checks++;
      if ({stall_EXE, done_EXE} !== {1'(c < 10), 1'b0}) begin
        errors++;
        $display("FAIL flush cycle %0d stall/done: got %b%b expected %b0", c, stall_EXE, done_EXE, 1'(c < 10));
      end
      next_cycle();
    end
    flush        = 1'b0;
    start_ID_EXE = 1'b0;
    @(negedge clk);
    check_idle("flush_then_idle");
    next_cycle();
    run_op(2'b10, 32'd100, 32'd7, "after_flush_divu");
  endtask

  task automatic test_flush_on_start();
    start_ID_EXE = 1'b1;
    flush        = 1'b1;
    op_ID_EXE    = 2'b00;
    A_FRWD       = 32'd3;
    B_FRWD       = 32'd4;
    @(negedge clk);
    check_idle("flush_with_start");
    next_cycle();
    start_ID_EXE = 1'b0;
    flush        = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle("flush_start_not_taken");
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_run();
    start_ID_EXE = 1'b1;
    op_ID_EXE    = 2'b00;
    A_FRWD       = 32'd123;
    B_FRWD       = 32'd456;
    for (int c = 0; c < 5; c++) next_cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("async_reset_mid_run");
    start_ID_EXE = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_idle("idle_after_mid_reset");
      next_cycle();
    end
    run_op(2'b00, 32'd123, 32'd456, "mul_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom();
      b  = (i == 3) ? 32'd0 : (($urandom() >> (i * 4)) | 32'd1);
      run_op(op, a, b, "back_to_back");
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_flush_on_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
